alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's single-cycle registered ALU. Operand width is a parameter, and operations use valid/ready handshakes on input and output. A multi-cycle shift-add multiplier replaces the single-cycle `*`. Full flag set (zero, carry, overflow, negative) is registered in the same cycle as the result, so flags never lag the result. Sits between register-file read and writeback in the datapath.

---
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready handshaked ALU with registered result and flags and a shift-add multiplier
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ul_a,
  input  logic [WIDTH-1:0] i_ul_b,
  input  logic [2:0]       i_u3_sel,
  input  logic             i_bi_valid,
  output logic             o_bi_ready,
  output logic [WIDTH-1:0] o_ul_r,
  output logic             o_bi_zflag,
  output logic             o_bi_cflag,
  output logic             o_bi_vflag,
  output logic             o_bi_nflag,
  output logic             o_bi_valid,
  input  logic             i_bi_ready
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, mplier_q, mplier_d, alu_r, ld_r;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, valid_q, valid_d;
  logic alu_c, alu_v, ld, ld_c, ld_v, accept;
  logic [WIDTH:0] sum, diff;
  assign sum = {1'b0, i_ul_a} + {1'b0, i_ul_b};
  assign diff = {1'b0, i_ul_a} - {1'b0, i_ul_b};
  assign o_bi_ready = (state_q == IDLE) && (!valid_q || i_bi_ready);
  assign accept = i_bi_valid && o_bi_ready;
  // Single-cycle result and carry/overflow for every opcode except multiply
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (i_u3_sel)
      3'b000: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (i_ul_a[WIDTH-1] == i_ul_b[WIDTH-1]) && (sum[WIDTH-1] != i_ul_a[WIDTH-1]);
      end
      3'b001: alu_r = i_ul_a & i_ul_b;
      3'b010: alu_r = i_ul_a | i_ul_b;
      3'b100: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (i_ul_a[WIDTH-1] != i_ul_b[WIDTH-1]) && (diff[WIDTH-1] != i_ul_a[WIDTH-1]);
      end
      3'b101: alu_r = WIDTH'(i_ul_a < i_ul_b);
      3'b110: alu_r = WIDTH'($signed(i_ul_a) < $signed(i_ul_b));
      3'b111: alu_r = i_ul_a ^ i_ul_b;
      default: alu_r = '0;
    endcase
  end
  // Next state: multiplier iteration, result/flag load and output slot occupancy
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ld = 1'b0;
    ld_r = alu_r;
    ld_c = alu_c;
    ld_v = alu_v;
    if (state_q == MUL) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        ld = 1'b1;
        ld_r = acc_d[WIDTH-1:0];
        ld_c = |acc_d[2*WIDTH-1:WIDTH];
        ld_v = 1'b0;
        state_d = IDLE;
      end
    end else if (accept) begin
      if (i_u3_sel == 3'b011) begin
        state_d = MUL;
        mcand_d = {{WIDTH{1'b0}}, i_ul_a};
        mplier_d = i_ul_b;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        ld = 1'b1;
      end
    end
    r_d = ld ? ld_r : r_q;
    z_d = ld ? ~|ld_r : z_q;
    c_d = ld ? ld_c : c_q;
    v_d = ld ? ld_v : v_q;
    n_d = ld ? ld_r[WIDTH-1] : n_q;
    valid_d = ld || (valid_q && !i_bi_ready);
  end
  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
      valid_q <= 1'b0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
      n_q <= n_d;
      valid_q <= valid_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_ul_r = r_q;
  assign o_bi_zflag = z_q;
  assign o_bi_cflag = c_q;
  assign o_bi_vflag = v_q;
  assign o_bi_nflag = n_q;
  assign o_bi_valid = valid_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8
module tb_alu_pipe;
  localparam int W = 8;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, dready;
  logic [W-1:0] a, b, r;
  logic [2:0] sel;
  logic z, c, v, n;
  int checks = 0, failures = 0, pops = 0, p0, p1;
  logic [W+3:0] sb[$];
  logic [W+3:0] exp_v;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_ul_a(a), .i_ul_b(b), .i_u3_sel(sel),
    .i_bi_valid(in_valid), .o_bi_ready(in_ready), .o_ul_r(r),
    .o_bi_zflag(z), .o_bi_cflag(c), .o_bi_vflag(v), .o_bi_nflag(n),
    .o_bi_valid(out_valid), .i_bi_ready(dready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] s);
    logic [W-1:0] rr;
    logic cc, vv;
    int sx, sy, t;
    logic [2*W-1:0] p;
    sx = $signed(x);
    sy = $signed(y);
    cc = 1'b0;
    vv = 1'b0;
    rr = '0;
    case (s)
      3'd0: begin
        rr = x + y;
        cc = (int'(x) + int'(y)) >= 2**W;
        t = sx + sy;
        vv = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      3'd1: rr = x & y;
      3'd2: rr = x | y;
      3'd3: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        rr = p[W-1:0];
        cc = p[2*W-1:W] != 0;
      end
      3'd4: begin
        rr = x - y;
        cc = x < y;
        t = sx - sy;
        vv = (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
      end
      3'd5: rr = {{(W-1){1'b0}}, x < y};
      3'd6: rr = {{(W-1){1'b0}}, sx < sy};
      default: rr = x ^ y;
    endcase
    return {rr, rr == 0, cc, vv, rr[W-1]};
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] s, input logic rdy);
    int k = 0;
    @(negedge clk);
    a = x;
    b = y;
    sel = s;
    in_valid = 1'b1;
    dready = rdy;
    #1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      dready = 1'b1;
      #1;
      k++;
    end
    check("accept", k < 100, 1);
    sb.push_back(model(x, y, s));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!out_valid && k < 40);
    check("valid_timeout", out_valid, 1);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && dready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        check("result", {r, z, c, v, n}, exp_v);
        pops++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sel = '0;
    dready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_r", r, 0);
    check("rst_flags", {z, c, v, n}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;
    issue(8'hFF, 8'h01, 3'b000, 1'b1);
    @(negedge clk);
    #1;
    check("add_r", r, 0);
    check("add_zcvn", {z, c, v, n}, 4'b1100);
    check("add_valid", out_valid, 1);
    issue(8'h80, 8'h01, 3'b100, 1'b1);
    issue(8'hFF, 8'h01, 3'b110, 1'b1);
    issue(8'hFF, 8'h01, 3'b101, 1'b1);
    issue(8'd6, 8'd7, 3'b011, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      #1;
      check("mul_busy", {in_ready, out_valid}, 0);
    end
    @(negedge clk);
    #1;
    check("mul_done", out_valid, 1);
    check("mul_r", r, 42);
    issue(8'h10, 8'h10, 3'b011, 1'b1);
    wait_valid();
    check("mul_hi_zc", {r, z, c}, {8'h00, 2'b11});
    issue(8'h12, 8'h34, 3'b000, 1'b1);
    dready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'hAA;
      sel = 3'b001;
      #1;
      check("hold_r", r, 8'h46);
      check("hold_flags", {z, c, v, n}, 0);
      check("hold_vr", {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    issue(8'h0F, 8'hF0, 3'b111, 1'b1);
    @(negedge clk);
    #1;
    check("nobubble", {out_valid, r}, {1'b1, 8'hFF});
    #2;
    p0 = pops;
    issue(8'hF0, 8'h0F, 3'b001, 1'b1);
    issue(8'hF0, 8'h0F, 3'b010, 1'b1);
    issue(8'hAA, 8'hAA, 3'b111, 1'b1);
    @(negedge clk);
    #3;
    check("b2b_count", pops - p0, 3);
    issue(8'h05, 8'h09, 3'b011, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    #1;
    check("rstmul_vr", {out_valid, in_ready}, 2'b01);
    check("rstmul_r", r, 0);
    rst = 1'b0;
    p1 = pops;
    repeat (20) @(negedge clk);
    #3;
    check("no_stale", {pops - p1, 31'(out_valid)}, 0);
    issue(8'd3, 8'd4, 3'b011, 1'b1);
    wait_valid();
    check("mul_after_rst", r, 12);
    for (int i = 0; i < 30; i++)
      issue(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    dready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    #3;
    check("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
